// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the EX-stage branch resolution / flush controller:
//   - RV32 opcode constants for conditional branches and jumps
//   - func3 encodings of the conditional branches
//   - 2-bit saturating counter type, its encodings and its update function
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;

    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        BLT  = 3'd4,
        BGE  = 3'd5,
        BLTU = 3'd6,
        BGEU = 3'd7
    } func3_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t SNT = 2'b00;
    localparam bht_cnt_t WNT = 2'b01;
    localparam bht_cnt_t WT  = 2'b10;
    localparam bht_cnt_t ST  = 2'b11;

    // Saturating step of a 2-bit counter toward the observed outcome.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t nxt;
        if (taken) begin
            nxt = (cnt == ST) ? ST : bht_cnt_t'(cnt + 2'b01);
        end else begin
            nxt = (cnt == SNT) ? SNT : bht_cnt_t'(cnt - 2'b01);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_flush_ctrl_bht_table.sv
// -----------------------------------------------------------------------------
// bht_table
// Direct-mapped table of 2-bit saturating branch counters.
// Ports:
//   clk       - clock, updates on rising edge
//   reset     - asynchronous active-high, all counters return to CNT_INIT
//   rd_idx    - read index (asynchronous read port)
//   rd_cnt    - counter at rd_idx, pre-update value in the write cycle
//   wr_en     - apply a saturating update this edge
//   wr_idx    - update index
//   wr_taken  - update direction (1 = toward taken)
// -----------------------------------------------------------------------------
module bht_table
    import branch_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6,
    parameter bht_cnt_t    CNT_INIT = 2'b01
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output bht_cnt_t            rd_cnt,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    bht_cnt_t table_r [ENTRIES];

    // Counter storage: asynchronous clear, one saturating update per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= CNT_INIT;
            end
        end else if (wr_en) begin
            table_r[wr_idx] <= bht_next(table_r[wr_idx], wr_taken);
        end
    end

    assign rd_cnt = table_r[rd_idx];

endmodule

// File: rtl/branch_flush_ctrl.sv
// -----------------------------------------------------------------------------
// branch_flush_ctrl
// EX-stage resolution of conditional branches and jumps with a BHT of 2-bit
// saturating counters feeding the IF-stage prediction. A flush is raised only
// on a conditional-branch mispredict or on JAL/JALR; a shadow counter masks
// the bubbles that follow a flush so they are never evaluated.
// Optional feature macro: BRANCH_PERF_CNT_EN (adds br_count / mispred_count).
// Ports:
//   clk, reset           - clock / asynchronous active-high reset
//   pc_if                - IF PC used for the table lookup
//   predict_taken_if     - MSB of the indexed counter (combinational)
//   valid_ex, stall      - EX holds a real instruction / pipeline frozen
//   op_ex, func3_ex      - EX opcode and func3
//   br_eq, br_lt         - comparator results
//   pc_ex                - EX PC, selects the counter to update
//   pred_taken_ex        - prediction carried with the instruction
//   flush                - squash IF/ID and ID/EX (combinational)
//   mispredict           - flush caused by a conditional-branch mispredict
//   br_count             - evaluated conditional branches (optional)
//   mispred_count        - mispredicts (optional)
//   taken_ex             - actual branch/jump outcome
// -----------------------------------------------------------------------------
module branch_flush_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned IDX_BITS      = 6,
    parameter int unsigned SHADOW_CYCLES = 2,
    parameter bht_cnt_t    CNT_INIT      = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_if,
    output logic            predict_taken_if,
    input  logic            valid_ex,
    input  logic            stall,
    input  logic [6:0]      op_ex,
    input  logic [2:0]      func3_ex,
    input  logic            br_eq,
    input  logic            br_lt,
    input  logic [XLEN-1:0] pc_ex,
    input  logic            pred_taken_ex,
    output logic            flush,
    output logic            mispredict,
`ifdef BRANCH_PERF_CNT_EN
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count,
`endif
    output logic            taken_ex
);

    localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW_CYCLES);

    logic [2:0] shadow_r;
    logic       eval_s;
    logic       is_branch_s;
    logic       is_jump_s;
    logic       actual_s;
    logic       legal_s;
    logic       wr_en_s;
    bht_cnt_t   rd_cnt_s;
    logic       unused_pc_s;

    // Only the index bits of the PCs address the table.
    assign unused_pc_s = ^{pc_if[XLEN-1:IDX_BITS+2], pc_if[1:0],
                           pc_ex[XLEN-1:IDX_BITS+2], pc_ex[1:0]};

    // Reset and the post-flush shadow both turn EX into a bubble.
    assign eval_s      = valid_ex & ~reset & (shadow_r == 3'd0);
    assign is_branch_s = (op_ex == OP_BRANCH);
    assign is_jump_s   = (op_ex == OP_JAL) | (op_ex == OP_JALR);

    // Branch outcome decode; func3 2/3 resolve not-taken and never train.
    always_comb begin
        actual_s = 1'b0;
        legal_s  = 1'b0;
        case (func3_ex)
            BEQ: begin
                actual_s = br_eq;
                legal_s  = 1'b1;
            end
            BNE: begin
                actual_s = ~br_eq;
                legal_s  = 1'b1;
            end
            BLT, BLTU: begin
                actual_s = br_lt;
                legal_s  = 1'b1;
            end
            BGE, BGEU: begin
                actual_s = ~br_lt;
                legal_s  = 1'b1;
            end
            default: begin
                actual_s = 1'b0;
                legal_s  = 1'b0;
            end
        endcase
    end

    // Zero-latency redirect controls, all forced low on a bubble.
    always_comb begin
        flush      = 1'b0;
        mispredict = 1'b0;
        taken_ex   = 1'b0;
        if (eval_s && is_jump_s) begin
            flush    = 1'b1;
            taken_ex = 1'b1;
        end else if (eval_s && is_branch_s) begin
            mispredict = (actual_s != pred_taken_ex);
            flush      = (actual_s != pred_taken_ex);
            taken_ex   = actual_s;
        end else begin
            flush      = 1'b0;
            mispredict = 1'b0;
            taken_ex   = 1'b0;
        end
    end

    assign wr_en_s = eval_s & ~stall & is_branch_s & legal_s;

    bht_table #(
        .IDX_BITS (IDX_BITS),
        .CNT_INIT (CNT_INIT)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (pc_if[IDX_BITS+1:2]),
        .rd_cnt   (rd_cnt_s),
        .wr_en    (wr_en_s),
        .wr_idx   (pc_ex[IDX_BITS+1:2]),
        .wr_taken (actual_s)
    );

    assign predict_taken_if = rd_cnt_s[1];

    // Shadow counter: a flush that is held by a stall keeps asserting and
    // only arms the shadow once the pipeline actually advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_r <= 3'd0;
        end else if (flush && !stall) begin
            shadow_r <= SHADOW_LOAD;
        end else if ((shadow_r != 3'd0) && !stall) begin
            shadow_r <= shadow_r - 3'd1;
        end else begin
            shadow_r <= shadow_r;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    // Performance counters; counted once per instruction, when EX advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else begin
            if (eval_s && is_branch_s && !stall) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict && !stall) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
module tb_branch_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_if;
    logic        predict_taken_if;
    logic        valid_ex;
    logic        stall;
    logic [6:0]  op_ex;
    logic [2:0]  func3_ex;
    logic        br_eq;
    logic        br_lt;
    logic [31:0] pc_ex;
    logic        pred_taken_ex;
    logic        flush;
    logic        mispredict;
    logic        taken_ex;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] br_count;
    logic [31:0] mispred_count;
`endif

    int checks = 0;
    int errors = 0;

    branch_flush_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .pc_if            (pc_if),
        .predict_taken_if (predict_taken_if),
        .valid_ex         (valid_ex),
        .stall            (stall),
        .op_ex            (op_ex),
        .func3_ex         (func3_ex),
        .br_eq            (br_eq),
        .br_lt            (br_lt),
        .pc_ex            (pc_ex),
        .pred_taken_ex    (pred_taken_ex),
        .flush            (flush),
        .mispredict       (mispredict),
`ifdef BRANCH_PERF_CNT_EN
        .br_count         (br_count),
        .mispred_count    (mispred_count),
`endif
        .taken_ex         (taken_ex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic eq, input logic lt, input logic [31:0] pc,
                      input logic pred);
        valid_ex      = v;
        op_ex         = op;
        func3_ex      = f3;
        br_eq         = eq;
        br_lt         = lt;
        pc_ex         = pc;
        pred_taken_ex = pred;
    endtask

    task automatic idle();
        ex(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic f, input logic m, input logic t);
        chk({tag, "_flush"}, flush, f);
        chk({tag, "_misp"}, mispredict, m);
        chk({tag, "_taken"}, taken_ex, t);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        pc_if = 32'h40;
        idle();
        #1;
        chk("rst_pred", predict_taken_if, 1'b0);
        ex(1'b1, 7'd111, 3'd0, 1'b0, 1'b0, 32'h40, 1'b0);
        #1;
        outs("rst_mask", 1'b0, 1'b0, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // BEQ taken, predicted not-taken: mispredict, counter 01 -> 10
        ex(1'b1, 7'd99, 3'd0, 1'b1, 1'b0, 32'h40, 1'b0);
        #1;
        outs("beq", 1'b1, 1'b1, 1'b1);
        chk("beq_pred_old", predict_taken_if, 1'b0);
        tick();

        // Mispredicting BNE (not taken, predicted taken) inside the shadow
        ex(1'b1, 7'd99, 3'd1, 1'b1, 1'b0, 32'h40, 1'b1);
        #1;
        outs("bne_sh2", 1'b0, 1'b0, 1'b0);
        chk("beq_pred_new", predict_taken_if, 1'b1);
        tick();
        outs("bne_sh1", 1'b0, 1'b0, 1'b0);
        chk("bne_sh1_noupd", predict_taken_if, 1'b1);
        tick();
        outs("bne_eval", 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        chk("bne_upd", predict_taken_if, 1'b0);
        tick();
        tick();

        // Four not-taken BLT at 0x80: 01 -> 00 and stays there
        pc_if = 32'h80;
        for (int i = 0; i < 4; i++) begin
            ex(1'b1, 7'd99, 3'd4, 1'b0, 1'b0, 32'h80, 1'b0);
            #1;
            chk("blt_nt_flush", flush, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("blt_sat_pred", predict_taken_if, 1'b0);
        ex(1'b1, 7'd99, 3'd4, 1'b0, 1'b1, 32'h80, 1'b0);
        #1;
        outs("blt_t", 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        #1;
        chk("blt_no_wrap", predict_taken_if, 1'b0);
        tick();
        tick();

        // JAL and JALR: always flush, never train
        pc_if = 32'h40;
        ex(1'b1, 7'd111, 3'd0, 1'b0, 1'b0, 32'h40, 1'b0);
        #1;
        outs("jal", 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        tick();
        ex(1'b1, 7'd103, 3'd0, 1'b0, 1'b0, 32'h40, 1'b0);
        #1;
        outs("jalr", 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        tick();
        chk("jmp_noupd", predict_taken_if, 1'b0);

        // Non-branch opcode
        ex(1'b1, 7'd51, 3'd0, 1'b1, 1'b1, 32'h40, 1'b1);
        #1;
        outs("alu", 1'b0, 1'b0, 1'b0);

        // Illegal func3 predicted taken: recovery flush, outcome not-taken
        ex(1'b1, 7'd99, 3'd2, 1'b1, 1'b1, 32'h40, 1'b1);
        #1;
        outs("illegal", 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();

        // Mispredicting BGE held by a stall
        ex(1'b1, 7'd99, 3'd5, 1'b0, 1'b0, 32'h40, 1'b0);
        stall = 1'b1;
        #1;
        outs("stall", 1'b1, 1'b1, 1'b1);
        tick();
        chk("stall_hold1", flush, 1'b1);
        chk("stall_noupd", predict_taken_if, 1'b0);
        tick();
        chk("stall_hold2", flush, 1'b1);
        stall = 1'b0;
        #1;
        chk("stall_rel", flush, 1'b1);
        tick();
        #1;
        chk("shadow_loaded", flush, 1'b0);
        chk("stall_upd", predict_taken_if, 1'b1);
        tick();
        idle();
        tick();

        // Correctly predicted taken BEQ: 10 -> 11, no flush
        ex(1'b1, 7'd99, 3'd0, 1'b1, 1'b0, 32'h40, 1'b1);
        #1;
        outs("beq_ok", 1'b0, 1'b0, 1'b1);
        tick();

        // Arm the shadow with a JAL, then reset while shadow = 1
        ex(1'b1, 7'd111, 3'd0, 1'b0, 1'b0, 32'h40, 1'b0);
        #1;
        chk("jal2_flush", flush, 1'b1);
        tick();
        tick();
        chk("sh1_mask", flush, 1'b0);
        chk("cnt_st_pred", predict_taken_if, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_pred", predict_taken_if, 1'b0);
        outs("arst", 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_PERF_CNT_EN
        chk32("arst_br_count", br_count, 32'd0);
        chk32("arst_mispred_count", mispred_count, 32'd0);
`endif
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_flush", flush, 1'b1);
        chk("post_rst_pred", predict_taken_if, 1'b0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
